palette_lut_pipe: RTL and testbench

// - Pipelined, runtime-writable palette decoder: maps (object id, encoded colour index) to 24-bit RGB.
// - Holds OBJ_NUM palettes of 2**COLOR_W entries in one storage array.
// - Sits between the frame decoder's SRAM pixel fetch and the VGA output stage.
// - Valid/ready pixel stream; separate write port lets game logic recolour objects (e.g. car mass level) between frames.

---
 rtl/palette_lut_pipe.sv | 178 +++++++++++++++++
 tb/tb_palette_lut_pipe.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/palette_lut_pipe.sv
// palette_lut_pipe: two-stage valid/ready palette decoder mapping (object id, colour index) to 24-bit RGB,
// with a runtime write port. Defining PALETTE_DIM_EN adds the i_dim per-channel right-shift input.
module palette_lut_pipe #(
    parameter int          OBJ_NUM       = 8,
    parameter int          OBJ_W         = 3,
    parameter int          COLOR_W       = 4,
    parameter logic [23:0] DEFAULT_COLOR = 24'hFFFFFF
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
`ifdef PALETTE_DIM_EN
    input  logic [1:0]         i_dim,
`endif
    input  logic               i_pix_valid,
    output logic               o_pix_ready,
    input  logic [OBJ_W-1:0]   i_object_id,
    input  logic [COLOR_W-1:0] i_encoded_color,
    output logic               o_pix_valid,
    input  logic               i_out_ready,
    output logic [23:0]        o_decoded_color,
    output logic               o_obj_hit,
    input  logic               i_wr_en,
    input  logic [OBJ_W-1:0]   i_wr_obj,
    input  logic [COLOR_W-1:0] i_wr_idx,
    input  logic [23:0]        i_wr_rgb,
    output logic               o_wr_ack,
    output logic               o_init_done
);
    localparam int              NUM_ENTRIES = OBJ_NUM * (2 ** COLOR_W);
    localparam int              AW          = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
    localparam logic [OBJ_W:0]  OBJ_LIMIT   = (OBJ_W + 1)'(OBJ_NUM);
    localparam logic [AW-1:0]   LAST_ADDR   = AW'(NUM_ENTRIES - 1);

    typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [AW-1:0]      cnt_r;
    logic               fill_en_s;
    logic               run_s;
    logic               wr_accept_s;
    logic [AW-1:0]      wr_addr_s;
    logic               adv_s;
    logic               a_valid_r;
    logic [OBJ_W-1:0]   a_obj_r;
    logic [COLOR_W-1:0] a_idx_r;
    logic               rd_hit_s;
    logic [AW-1:0]      rd_addr_s;
    logic [23:0]        rd_rgb_s;
    logic [23:0]        palette_mem [NUM_ENTRIES];

`ifdef PALETTE_DIM_EN
    function automatic logic [23:0] dim_rgb(input logic [23:0] rgb, input logic [1:0] dim);
        dim_rgb = {rgb[23:16] >> dim, rgb[15:8] >> dim, rgb[7:0] >> dim};
    endfunction
`endif

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_INIT;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic: INIT walks every entry once, RUN is terminal
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (cnt_r == LAST_ADDR) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_INIT;
                end
            end
            ST_RUN:  state_next_s = ST_RUN;
            default: state_next_s = ST_INIT;
        endcase
    end

    // FSM output decode
    always_comb begin
        fill_en_s = 1'b0;
        run_s     = 1'b0;
        case (state_r)
            ST_INIT: fill_en_s = 1'b1;
            ST_RUN:  run_s     = 1'b1;
            default: begin
                fill_en_s = 1'b0;
                run_s     = 1'b0;
            end
        endcase
    end

    // Fill counter and init-done flag
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_r       <= '0;
            o_init_done <= 1'b0;
        end else begin
            if (fill_en_s) begin
                cnt_r <= cnt_r + AW'(1);
            end
            o_init_done <= (state_next_s == ST_RUN);
        end
    end

    assign wr_accept_s = run_s && i_wr_en && ({1'b0, i_wr_obj} < OBJ_LIMIT);
    assign wr_addr_s   = AW'({i_wr_obj, i_wr_idx});

    // Palette storage: not reset, the INIT fill reloads it after every reset
    always_ff @(posedge i_clk) begin
        if (fill_en_s) begin
            palette_mem[cnt_r] <= DEFAULT_COLOR;
        end else if (wr_accept_s) begin
            palette_mem[wr_addr_s] <= i_wr_rgb;
        end
    end

    // Write acknowledge pulse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_wr_ack <= 1'b0;
        end else begin
            o_wr_ack <= wr_accept_s;
        end
    end

    assign adv_s       = !o_pix_valid || i_out_ready;
    assign o_pix_ready = o_init_done && adv_s;

    // Stage A: capture the accepted pixel request
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_valid_r <= 1'b0;
            a_obj_r   <= '0;
            a_idx_r   <= '0;
        end else if (adv_s) begin
            a_valid_r <= i_pix_valid && o_pix_ready;
            a_obj_r   <= i_object_id;
            a_idx_r   <= i_encoded_color;
        end
    end

    // Stage B read: re-evaluated every cycle so a held pixel sees fresh writes
    always_comb begin
        rd_hit_s  = ({1'b0, a_obj_r} < OBJ_LIMIT);
        rd_addr_s = '0;
        rd_rgb_s  = DEFAULT_COLOR;
        if (rd_hit_s) begin
            rd_addr_s = AW'({a_obj_r, a_idx_r});
            rd_rgb_s  = palette_mem[rd_addr_s];
        end else begin
            rd_addr_s = '0;
            rd_rgb_s  = DEFAULT_COLOR;
        end
`ifdef PALETTE_DIM_EN
        rd_rgb_s = dim_rgb(rd_rgb_s, i_dim);
`endif
    end

    // Stage B: registered RGB output, held while downstream stalls
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_pix_valid     <= 1'b0;
            o_decoded_color <= 24'h000000;
            o_obj_hit       <= 1'b0;
        end else if (adv_s) begin
            o_pix_valid <= a_valid_r;
            if (a_valid_r) begin
                o_decoded_color <= rd_rgb_s;
                o_obj_hit       <= rd_hit_s;
            end
        end
    end
endmodule

// File: tb/tb_palette_lut_pipe.sv
// Directed self-checking bench for palette_lut_pipe (OBJ_NUM=8, OBJ_W=4 so out-of-range ids are reachable).
module tb_palette_lut_pipe;
    logic        clk;
    logic        rst_n;
    logic        pix_valid;
    logic        pix_ready;
    logic [3:0]  pix_obj;
    logic [3:0]  pix_idx;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_rgb;
    logic        out_hit;
    logic        wr_en;
    logic [3:0]  wr_obj;
    logic [3:0]  wr_idx;
    logic [23:0] wr_rgb;
    logic        wr_ack;
    logic        init_done;
`ifdef PALETTE_DIM_EN
    logic [1:0]  dim;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    palette_lut_pipe #(
        .OBJ_NUM(8), .OBJ_W(4), .COLOR_W(4), .DEFAULT_COLOR(24'hFFFFFF)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
`ifdef PALETTE_DIM_EN
        .i_dim(dim),
`endif
        .i_pix_valid(pix_valid),
        .o_pix_ready(pix_ready),
        .i_object_id(pix_obj),
        .i_encoded_color(pix_idx),
        .o_pix_valid(out_valid),
        .i_out_ready(out_ready),
        .o_decoded_color(out_rgb),
        .o_obj_hit(out_hit),
        .i_wr_en(wr_en),
        .i_wr_obj(wr_obj),
        .i_wr_idx(wr_idx),
        .i_wr_rgb(wr_rgb),
        .o_wr_ack(wr_ack),
        .o_init_done(init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] stream_rgb(input int i);
        return {8'h30, 8'(i), 8'(i * 3)};
    endfunction

    // Counts cycles from reset release to init_done; an INIT-time write must be dropped.
    task automatic wait_init();
        int n;
        int rdy_seen;
        int ack_seen;
        n = 0;
        rdy_seen = 0;
        ack_seen = 0;
        while (!init_done && n < 200) begin
            if (n == 50) begin
                wr_en  = 1'b1;
                wr_obj = 4'd0;
                wr_idx = 4'd0;
                wr_rgb = 24'hBADBAD;
            end else begin
                wr_en = 1'b0;
            end
            tick();
            n++;
            if (pix_ready && !init_done) rdy_seen++;
            if (wr_ack) ack_seen++;
        end
        wr_en = 1'b0;
        chk("fill_cycles", n, 128);
        chk("ready_during_fill", rdy_seen, 0);
        chk("ack_during_fill", ack_seen, 0);
    endtask

    task automatic send_pix(input logic [3:0] obj, input logic [3:0] idx);
        pix_valid = 1'b1;
        pix_obj   = obj;
        pix_idx   = idx;
        tick();
        pix_valid = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [3:0] obj, input logic [3:0] idx,
                            input logic [23:0] exp_rgb, input logic exp_hit);
        send_pix(obj, idx);
        chk({tag, "_lat1"}, out_valid, 1'b0);
        tick();
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_rgb"}, out_rgb, exp_rgb);
        chk({tag, "_hit"}, out_hit, exp_hit);
    endtask

    task automatic wr(input string tag, input logic [3:0] obj, input logic [3:0] idx,
                      input logic [23:0] rgb, input logic exp_ack);
        wr_en  = 1'b1;
        wr_obj = obj;
        wr_idx = idx;
        wr_rgb = rgb;
        tick();
        wr_en = 1'b0;
        chk({tag, "_ack"}, wr_ack, exp_ack);
    endtask

    initial begin
        int out_idx;
        int in_idx;
        int cyc;
        logic held_v;
        logic [23:0] held_c;

        rst_n = 1'b0;
        pix_valid = 1'b0;
        pix_obj = 4'd0;
        pix_idx = 4'd0;
        out_ready = 1'b1;
        wr_en = 1'b0;
        wr_obj = 4'd0;
        wr_idx = 4'd0;
        wr_rgb = 24'h000000;
`ifdef PALETTE_DIM_EN
        dim = 2'd0;
`endif
        #23;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_rgb", out_rgb, 24'h000000);
        chk("rst_hit", out_hit, 1'b0);
        chk("rst_ack", wr_ack, 1'b0);
        chk("rst_init", init_done, 1'b0);
        chk("rst_ready", pix_ready, 1'b0);

        tick();
        rst_n = 1'b1;
        wait_init();
        chk("ready_after_init", pix_ready, 1'b1);

        read_chk("default_2_5", 4'd2, 4'd5, 24'hFFFFFF, 1'b1);
        read_chk("init_write_dropped", 4'd0, 4'd0, 24'hFFFFFF, 1'b1);
        wr("wr_2_5", 4'd2, 4'd5, 24'h123456, 1'b1);
        tick();
        chk("ack_pulse_end", wr_ack, 1'b0);
        read_chk("new_2_5", 4'd2, 4'd5, 24'h123456, 1'b1);

        // Pixel (1,3) sits in stage A while the write to (1,3) commits.
        send_pix(4'd1, 4'd3);
        wr("wr_1_3", 4'd1, 4'd3, 24'hAA0000, 1'b1);
        chk("same_cycle_valid", out_valid, 1'b1);
        chk("same_cycle_old", out_rgb, 24'hFFFFFF);
        read_chk("after_write_1_3", 4'd1, 4'd3, 24'hAA0000, 1'b1);

        for (int i = 0; i < 16; i++) begin
            wr("wr_obj3", 4'd3, 4'(i), stream_rgb(i), 1'b1);
        end

        out_idx = 0;
        in_idx = 0;
        cyc = 0;
        held_v = 1'b0;
        held_c = 24'h000000;
        while (out_idx < 16 && cyc < 200) begin
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            pix_valid = (in_idx < 16);
            pix_obj   = 4'd3;
            pix_idx   = 4'(in_idx);
            #1;
            if (held_v) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_rgb", out_rgb, held_c);
            end
            held_v = out_valid && !out_ready;
            held_c = out_rgb;
            if (out_valid && out_ready) begin
                chk("stream_rgb", out_rgb, stream_rgb(out_idx));
                out_idx++;
            end
            if (pix_valid && pix_ready) in_idx++;
            tick();
            cyc++;
        end
        pix_valid = 1'b0;
        out_ready = 1'b1;
        chk("stream_count", out_idx, 16);
        tick();
        tick();
        chk("stream_no_extra", out_valid, 1'b0);

        read_chk("obj7", 4'd7, 4'd15, 24'hFFFFFF, 1'b1);
        wr("wr_0_0", 4'd0, 4'd0, 24'h010101, 1'b1);
        read_chk("obj8_miss", 4'd8, 4'd0, 24'hFFFFFF, 1'b0);
        read_chk("obj15_miss", 4'd15, 4'd9, 24'hFFFFFF, 1'b0);
        wr("wr_obj8", 4'd8, 4'd0, 24'h00FF00, 1'b0);
        read_chk("obj0_intact", 4'd0, 4'd0, 24'h010101, 1'b1);

`ifdef PALETTE_DIM_EN
        wr("wr_dim", 4'd5, 4'd1, 24'hFF8040, 1'b1);
        dim = 2'd2;
        read_chk("dim2", 4'd5, 4'd1, 24'h3F2010, 1'b1);
        dim = 2'd0;
`endif

        // Two pixels in flight, then asynchronous reset between edges.
        pix_valid = 1'b1;
        pix_obj = 4'd2;
        pix_idx = 4'd5;
        tick();
        pix_obj = 4'd1;
        pix_idx = 4'd3;
        tick();
        pix_valid = 1'b0;
        chk("inflight_valid", out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_init", init_done, 1'b0);
        chk("midrst_ready", pix_ready, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        wait_init();
        read_chk("refill_2_5", 4'd2, 4'd5, 24'hFFFFFF, 1'b1);
        read_chk("refill_1_3", 4'd1, 4'd3, 24'hFFFFFF, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
